pipeline_arith_hs: RTL and testbench
====================================

// Module: pipeline_arith_hs
// PURPOSE
//  Parametrised 3-stage pipelined arithmetic datapath computing (a+b)*(c-d) per beat,
//  with valid/ready flow control, optional running accumulation and output saturation.
//  Sits between an upstream operand source and a downstream result consumer.
//  Throughput one beat/cycle when out_ready stays high.
// PARAMETERS
//  W      8   operand width (unsigned a,b,c,d)
//  OUT_W  16  signed result width on out
//  SAT    1   1: clamp result to signed OUT_W range; 0: truncate to OUT_W LSBs (two's complement wrap)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      pipeline accepts beat this cycle
//  a,b,c,d    in   W each unsigned operands
//  acc_en     in   1      beat adds its product into accumulator; out shows new accumulator
//  acc_start  in   1      with acc_en: accumulator restarts at this beat's product
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out        out  OUT_W  signed result
//  ovf        out  1      result saturated (SAT=1) or wrapped (SAT=0) for this beat
// BEHAVIOUR
//  - Reset: all stage valid bits 0, out_valid=0, out=0, ovf=0, accumulator=0. Reset mid-run drops all in-flight beats.
//  - Transfer: in on in_valid&in_ready; out on out_valid&out_ready.
//  - Stage k loads when empty or stage k+1 loads/drains in same cycle; S3 drains on out_ready.
//  - in_ready = !v1 | S1 advances (combinational chain from out_ready; no bubbles under steady flow).
//  - Inputs may change freely while in_valid=0 or in_ready=0; only accepted beats are processed.
//  - S1: sum = a+b (W+1 bits unsigned); diff = c-d as signed W+1 bits; acc_en/acc_start registered.
//  - S2: prod = sum*diff, signed 2W+3 bits, exact (no overflow possible).
//  - S3: acc_en=0 -> res=prod, accumulator unchanged.
//        acc_en=1,acc_start=1 -> acc=prod; acc_en=1,acc_start=0 -> acc=acc+prod; res=acc new value.
//        Accumulator signed 2W+11 bits, internal wrap permitted beyond that; updates only when S3 loads.
//  - Output: SAT=1 -> out=clamp(res, -2^(OUT_W-1), 2^(OUT_W-1)-1), ovf=1 iff clamped.
//            SAT=0 -> out=res[OUT_W-1:0], ovf=1 iff res outside signed OUT_W range.
//  - out/ovf held stable while out_valid=1 and out_ready=0; accumulator never updated by a stalled beat.
//  - Latency: beat accepted in cycle N -> out_valid in cycle N+3 (out_ready=1 throughout).
//  - Stall: out_ready=0 fills S3,S2,S1 then in_ready=0 (max 3 beats held); no beat lost or duplicated.
//  - Simultaneous: drain at S3 and load at S1 in same cycle both occur when pipeline full.
//  - out_valid falls to 0 when pipeline empties; out keeps last value.
// TESTING
//  1 rst=1 two cycles, then idle -> out_valid=0,out=0,ovf=0,in_ready=1.
//  2 W=8,OUT_W=16,SAT=1, back-to-back (4,5,3,2),(10,3,15,5),(20,4,4,2),(15,2,10,4), acc_en=0
//    -> out 9,130,48,102 on cycles N+3..N+6, ovf=0.
//  3 (4,5,2,5) -> out=-27 (0xFFE5), ovf=0; (255,255,255,0) -> out=32767, ovf=1; SAT=0 same -> out=0xFC02, ovf=1.
//  4 acc_en=1 on the four beats of 2, acc_start=1 on first -> out 9,139,187,289; next beat acc_start=1 (4,5,3,2) -> 9.
//  5 out_ready=0 for 6 cycles during stream of 2 -> in_ready=0 after 3 held beats, out stable;
//    release -> all 4 results in order, no duplicates; accumulate variant gives 289 exactly once.
//  6 rst pulse with 3 beats in flight -> out_valid=0 next cycle, accumulator=0, new beat after reset gives correct result.

Source files
------------

// File: rtl/pipeline_arith_hs.sv
// pipeline_arith_hs
// Three-stage pipelined datapath computing (a+b)*(c-d) per beat. It uses valid/ready flow
// control and has an optional running accumulator. The result is either saturated or
// wrapped to a signed OUT_W-bit output.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake; a, b, c, d are unsigned W-bit operands
//   acc_en, acc_start    per-beat accumulate control (acc_start restarts the accumulator)
//   out_valid/out_ready  result handshake
//   out, ovf             signed OUT_W-bit result and saturate/wrap flag
//
// Assumes OUT_W <= 2*W+11 (the accumulator width).
module pipeline_arith_hs #(
    parameter int unsigned W     = 8,
    parameter int unsigned OUT_W = 16,
    parameter bit          SAT   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            a,
    input  logic [W-1:0]            b,
    input  logic [W-1:0]            c,
    input  logic [W-1:0]            d,
    input  logic                    acc_en,
    input  logic                    acc_start,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out,
    output logic                    ovf
);

    localparam int unsigned PW = 2 * W + 3;   // exact product width
    localparam int unsigned AW = 2 * W + 11;  // accumulator width

    logic v1_q, v2_q, v3_q;
    logic adv1, adv2, adv3;

    // Each stage may load when empty or when the stage after it moves on in the same cycle.
    // This gives a combinational ready chain from out_ready, so there are no bubbles.
    assign adv3      = !v3_q || out_ready;
    assign adv2      = !v2_q || adv3;
    assign adv1      = !v1_q || adv2;
    assign in_ready  = adv1;
    assign out_valid = v3_q;

    // Stage 1: sum and difference
    logic [W:0]        sum_q;
    logic signed [W:0] diff_q;
    logic              en1_q, st1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
        end else if (adv1) begin
            v1_q <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv1 && in_valid) begin
            sum_q  <= {1'b0, a} + {1'b0, b};
            diff_q <= {1'b0, c} - {1'b0, d};
            en1_q  <= acc_en;
            st1_q  <= acc_start;
        end
    end

    // Stage 2: exact signed product
    logic signed [PW-1:0] sum_x, diff_x, prod_d, prod_q;
    logic                 en2_q, st2_q;

    assign sum_x  = $signed({{(PW - W - 1){1'b0}}, sum_q});
    assign diff_x = $signed({{(PW - W - 1){diff_q[W]}}, diff_q});
    // Product of the operand magnitudes always fits PW bits, so truncation is exact.
    assign prod_d = sum_x * diff_x;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q <= 1'b0;
        end else if (adv2) begin
            v2_q <= v1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (adv2 && v1_q) begin
            prod_q <= prod_d;
            en2_q  <= en1_q;
            st2_q  <= st1_q;
        end
    end

    // Stage 3: accumulate, then saturate or wrap
    logic signed [AW-1:0]    prod_a, acc_q, acc_next, res;
    logic                    outside;
    logic signed [OUT_W-1:0] out_d;

    always_comb begin
        prod_a   = {{(AW - PW){prod_q[PW-1]}}, prod_q};
        acc_next = st2_q ? prod_a : acc_q + prod_a;
        res      = en2_q ? acc_next : prod_a;
        // Fits in OUT_W signed iff all bits from the OUT_W sign bit upward agree.
        outside  = !((&res[AW-1:OUT_W-1]) || !(|res[AW-1:OUT_W-1]));
        out_d    = res[OUT_W-1:0];
        if (SAT && outside) begin
            out_d = res[AW-1] ? {1'b1, {(OUT_W - 1){1'b0}}} : {1'b0, {(OUT_W - 1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q  <= 1'b0;
            acc_q <= '0;
            out   <= '0;
            ovf   <= 1'b0;
        end else begin
            if (adv3) begin
                v3_q <= v2_q;
            end
            // Only a real beat entering S3 touches the accumulator and output registers.
            if (adv3 && v2_q) begin
                if (en2_q) begin
                    acc_q <= acc_next;
                end
                out <= out_d;
                ovf <= outside;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_arith_hs.sv
module tb_pipeline_arith_hs;

    typedef struct {
        logic [7:0]  a, b, c, d;
        logic        en, st;
        logic [15:0] es;
        logic        os;
        logic [15:0] ew;
        logic        ow;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        os;
        logic [15:0] w;
        logic        ow;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [7:0]  a = '0, b = '0, c = '0, d = '0;
    logic        acc_en = 1'b0, acc_start = 1'b0;
    logic        in_ready, out_valid, ovf;
    logic [15:0] out;
    logic        in_ready_w, out_valid_w, ovf_w;
    logic [15:0] out_w;

    int total = 0;
    int bad = 0;
    int acc_count = 0;
    int pops = 0;
    vec_t tab[14];
    exp_t q[$];
    logic [15:0] recv[$];
    longint acc_m = 0;

    always #5 clk = ~clk;

    pipeline_arith_hs #(.W(8), .OUT_W(16), .SAT(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .d(d), .acc_en(acc_en), .acc_start(acc_start),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .ovf(ovf)
    );

    pipeline_arith_hs #(.W(8), .OUT_W(16), .SAT(1'b0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .a(a), .b(b), .c(c), .d(d), .acc_en(acc_en), .acc_start(acc_start),
        .out_valid(out_valid_w), .out_ready(out_ready), .out(out_w), .ovf(ovf_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sv(input int i, input int va, input int vb, input int vc, input int vd,
                      input bit en, input bit st, input int es, input bit os,
                      input int ew, input bit ow);
        tab[i].a  = 8'(va);
        tab[i].b  = 8'(vb);
        tab[i].c  = 8'(vc);
        tab[i].d  = 8'(vd);
        tab[i].en = en;
        tab[i].st = st;
        tab[i].es = 16'(es);
        tab[i].os = os;
        tab[i].ew = 16'(ew);
        tab[i].ow = ow;
    endtask

    task automatic drive(input vec_t v);
        a = v.a;
        b = v.b;
        c = v.c;
        d = v.d;
        acc_en = v.en;
        acc_start = v.st;
        in_valid = 1'b1;
    endtask

    // Reference model: plain integer arithmetic on accepted beats, in acceptance order.
    initial begin
        logic hold;
        logic [15:0] held_out;
        logic held_ovf;
        hold = 1'b0;
        held_out = '0;
        held_ovf = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                acc_m = 0;
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_out", 32'(out), 32'(held_out));
                    check("hold_ovf", 32'(ovf), 32'(held_ovf));
                end
                hold = out_valid && !out_ready;
                held_out = out;
                held_ovf = ovf;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_out: got output %0h, expected none", out);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check("model_out", 32'(out), 32'(e.s));
                        check("model_ovf", 32'(ovf), 32'(e.os));
                        check("model_wrap_valid", 32'(out_valid_w), 32'd1);
                        check("model_wrap_out", 32'(out_w), 32'(e.w));
                        check("model_wrap_ovf", 32'(ovf_w), 32'(e.ow));
                        recv.push_back(out);
                        pops++;
                    end
                end
                if (in_valid && in_ready) begin
                    longint p, r;
                    bit outside;
                    exp_t e;
                    p = (longint'(a) + longint'(b)) * (longint'(c) - longint'(d));
                    if (acc_en) begin
                        acc_m = acc_start ? p : acc_m + p;
                        acc_m = acc_m & 64'h7FF_FFFF;
                        if (acc_m >= 64'h400_0000) acc_m = acc_m - 64'h800_0000;
                        r = acc_m;
                    end else begin
                        r = p;
                    end
                    outside = (r > 32767) || (r < -32768);
                    e.w  = r[15:0];
                    e.ow = outside;
                    e.os = outside;
                    e.s  = outside ? ((r < 0) ? 16'h8000 : 16'h7FFF) : r[15:0];
                    q.push_back(e);
                    acc_count++;
                end
            end
        end
    end

    // Back-to-back beats with out_ready high; each result must appear three cycles later.
    task automatic run_table(input int first, input int n);
        for (int j = 0; j < n + 3; j++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            if (j < n) begin
                drive(tab[first + j]);
                check("tab_in_ready", 32'(in_ready), 32'd1);
                check("tab_in_ready_w", 32'(in_ready_w), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            if (j >= 3) begin
                check("tab_valid", 32'(out_valid), 32'd1);
                check("tab_out", 32'(out), 32'(tab[first + j - 3].es));
                check("tab_ovf", 32'(ovf), 32'(tab[first + j - 3].os));
                check("tab_wrap_out", 32'(out_w), 32'(tab[first + j - 3].ew));
                check("tab_wrap_ovf", 32'(ovf_w), 32'(tab[first + j - 3].ow));
            end
        end
        @(posedge clk);
        #1;
        check("tab_empty_valid", 32'(out_valid), 32'd0);
        check("tab_keep_out", 32'(out), 32'(tab[first + n - 1].es));
    endtask

    // Stream with out_ready held low for a window; results must arrive once, in order.
    task automatic run_stream(input int first, input int n, input int stall_start,
                              input int stall_len);
        int base_acc, base_recv, cyc, k;
        base_acc = acc_count;
        base_recv = recv.size();
        cyc = 0;
        while ((recv.size() - base_recv < n) && cyc < 100) begin
            @(posedge clk);
            #1;
            out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
            k = acc_count - base_acc;
            if (k < n) drive(tab[first + k]);
            else in_valid = 1'b0;
            if (cyc == stall_start + stall_len - 1) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_held_beats", 32'(acc_count - base_acc), 32'd3);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_out", 32'(out), 32'(tab[first].es));
            end
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stream_count", 32'(recv.size() - base_recv), 32'(n));
        for (int i = 0; i < n && base_recv + i < recv.size(); i++) begin
            check("stream_order", 32'(recv[base_recv + i]), 32'(tab[first + i].es));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n289, p0;
        sv(0, 4, 5, 3, 2, 0, 0, 9, 0, 9, 0);
        sv(1, 10, 3, 15, 5, 0, 0, 130, 0, 130, 0);
        sv(2, 20, 4, 4, 2, 0, 0, 48, 0, 48, 0);
        sv(3, 15, 2, 10, 4, 0, 0, 102, 0, 102, 0);
        sv(4, 4, 5, 2, 5, 0, 0, 'hFFE5, 0, 'hFFE5, 0);
        sv(5, 255, 255, 255, 0, 0, 0, 'h7FFF, 1, 'hFC02, 1);
        sv(6, 255, 255, 0, 255, 0, 0, 'h8000, 1, 'h03FE, 1);
        sv(7, 1, 0, 0, 255, 0, 0, 'hFF01, 0, 'hFF01, 0);
        sv(8, 4, 5, 3, 2, 1, 1, 9, 0, 9, 0);
        sv(9, 10, 3, 15, 5, 1, 0, 139, 0, 139, 0);
        sv(10, 20, 4, 4, 2, 1, 0, 187, 0, 187, 0);
        sv(11, 15, 2, 10, 4, 1, 0, 289, 0, 289, 0);
        sv(12, 4, 5, 3, 2, 1, 1, 9, 0, 9, 0);
        sv(13, 4, 5, 3, 2, 1, 0, 9, 0, 9, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Plain products, signed results, saturation/wrap corners, then accumulation
        run_table(0, 8);
        run_table(8, 5);

        // Stalls: plain and accumulate variants
        run_stream(0, 4, 1, 6);
        p0 = recv.size();
        run_stream(8, 4, 1, 6);
        n289 = 0;
        for (int i = p0; i < recv.size(); i++) if (recv[i] == 16'd289) n289++;
        check("acc_289_once", 32'(n289), 32'd1);

        // Reset with three beats in flight, then a non-restarting accumulate beat
        out_ready = 1'b0;
        for (int i = 8; i < 11; i++) begin
            @(posedge clk);
            #1;
            drive(tab[i]);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out", 32'(out), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        run_table(13, 1);

        // Randomized traffic against the model
        p0 = pops;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = 8'($urandom);
            b = 8'($urandom);
            c = 8'($urandom);
            d = 8'($urandom);
            acc_en = 1'($urandom_range(0, 1));
            acc_start = ($urandom_range(0, 4) == 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 32'(q.size()), 32'd0);
        check("random_beats_seen", 32'(pops - p0 > 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
